// File: rtl/mac_disp_pkg.sv
// rtl/mac_disp_pkg.sv - shared state type, segment constants and glyph helper for mac_result_display
package mac_disp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2,
    SHOW    = 2'd3
  } state_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Largest value that fits on six decimal digits
  localparam logic [31:0] DEC_MAX = 32'd999999;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative double-dabble binary to 8-digit BCD converter, one bit per cycle
module bin2bcd_seq #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       bcd_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] bin_q;
  logic [31:0]       bcd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic [27:0]       adj_d;
  logic [31:0]       bcd_d;

  // Add-3 correction on the lower seven digits, then shift in the next input MSB.
  // The top digit never reaches 5 for inputs of at most 24 bits (max 16,777,215).
  always_comb begin
    adj_d = bcd_q[27:0];
    for (int i = 0; i < 7; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_d = {bcd_q[30:28], adj_d, bin_q[DATA_W-1]};
  end

  // Load on start, then DATA_W shift cycles; busy falls at the edge of the last shift
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      bin_q  <= din_i;
      bcd_q  <= '0;
      cnt_q  <= CNT_W'(DATA_W);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      bin_q <= {bin_q[DATA_W-2:0], 1'b0};
      bcd_q <= bcd_d;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_q <= 1'b0;
      end
    end
  end

  // done marks the final shift cycle so the consumer can advance on the same edge
  assign done_o = busy_q && (cnt_q == CNT_W'(1));
  assign busy_o = busy_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/mac_result_display.sv
// rtl/mac_result_display.sv - MAC result capture and 6-digit hex/decimal 7-segment display; option LEADING_ZERO_BLANK_EN
module mac_result_display
  import mac_disp_pkg::*;
#(
  parameter int DATA_W  = 24,
  parameter int NUM_DIG = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] result,
  input  logic              result_valid,
  input  logic              disp_en,
  input  logic              dec_mode,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3,
  output logic [6:0]        HEX4,
  output logic [6:0]        HEX5,
  output logic              busy,
  output logic              done
);

  localparam int HEX_W = 4 * NUM_DIG;

  state_e            state_q;
  logic [DATA_W-1:0] held_q;
  logic              mode_q;
  logic              done_q;
  logic [6:0]        seg_q [NUM_DIG];
  logic [6:0]        seg_d [NUM_DIG];
  logic [3:0]        nib [NUM_DIG];
  logic [HEX_W-1:0]  hex_val;
  logic              overflow;
  logic              accept;
  logic              toggle;
  logic              conv_start;
  logic [DATA_W-1:0] conv_din;
  logic              conv_busy;
  logic              conv_done;
  logic [31:0]       conv_bcd;
`ifdef LEADING_ZERO_BLANK_EN
  logic              lead_zero;
`endif

  // A new capture or a mode change while showing starts a fresh render
  assign accept     = ((state_q == IDLE) || (state_q == SHOW)) && result_valid;
  assign toggle     = (state_q == SHOW) && (dec_mode != mode_q);
  assign conv_start = (accept || toggle) && dec_mode;
  assign conv_din   = accept ? result : held_q;

  bin2bcd_seq #(
    .DATA_W(DATA_W)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (conv_start),
    .din_i   (conv_din),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  assign hex_val = HEX_W'(held_q);

  // Pick the digit source for the current render mode
  always_comb begin
    for (int i = 0; i < NUM_DIG; i++) begin
      nib[i] = mode_q ? conv_bcd[4*i +: 4] : hex_val[4*i +: 4];
    end
    overflow = mode_q && ((conv_bcd[31:HEX_W] != '0) || (32'(held_q) > DEC_MAX));
  end

  // Glyph lookup with optional leading-zero blanking and decimal overflow dashes
  always_comb begin
    for (int i = 0; i < NUM_DIG; i++) begin
      seg_d[i] = SEG_BLANK;
    end
`ifdef LEADING_ZERO_BLANK_EN
    lead_zero = 1'b1;
    for (int i = NUM_DIG - 1; i >= 0; i--) begin
      if (nib[i] != 4'd0) begin
        lead_zero = 1'b0;
      end
      seg_d[i] = (lead_zero && (i != 0)) ? SEG_BLANK : hex_to_seg(nib[i]);
      if (overflow) begin
        seg_d[i] = SEG_DASH;
      end
    end
`else
    for (int i = 0; i < NUM_DIG; i++) begin
      seg_d[i] = overflow ? SEG_DASH : hex_to_seg(nib[i]);
    end
`endif
  end

  // Control FSM: capture, wait for conversion, load digit registers, show
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      held_q  <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_DIG; i++) begin
        seg_q[i] <= SEG_BLANK;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, SHOW: begin
          if (accept) begin
            held_q  <= result;
            mode_q  <= dec_mode;
            state_q <= dec_mode ? CONVERT : LOAD;
          end else if (toggle) begin
            mode_q  <= dec_mode;
            state_q <= dec_mode ? CONVERT : LOAD;
          end
        end
        CONVERT: begin
          if (conv_done) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          for (int i = 0; i < NUM_DIG; i++) begin
            seg_q[i] <= seg_d[i];
          end
          done_q  <= 1'b1;
          state_q <= SHOW;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign HEX0 = disp_en ? seg_q[0] : SEG_BLANK;
  assign HEX1 = disp_en ? seg_q[1] : SEG_BLANK;
  assign HEX2 = disp_en ? seg_q[2] : SEG_BLANK;
  assign HEX3 = disp_en ? seg_q[3] : SEG_BLANK;
  assign HEX4 = disp_en ? seg_q[4] : SEG_BLANK;
  assign HEX5 = disp_en ? seg_q[5] : SEG_BLANK;
  assign busy = conv_busy;
  assign done = done_q;

endmodule

// File: tb/tb_mac_result_display.sv
// tb/tb_mac_result_display.sv - table-driven self-checking bench for mac_result_display
module tb_mac_result_display;

  logic        clk;
  logic        rst_n;
  logic [23:0] result;
  logic        result_valid;
  logic        disp_en;
  logic        dec_mode;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic        busy;
  logic        done;

  int nchecks = 0;
  int nfail   = 0;

  mac_result_display #(
    .DATA_W  (24),
    .NUM_DIG (6)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .result       (result),
    .result_valid (result_valid),
    .disp_en      (disp_en),
    .dec_mode     (dec_mode),
    .HEX0         (HEX0),
    .HEX1         (HEX1),
    .HEX2         (HEX2),
    .HEX3         (HEX3),
    .HEX4         (HEX4),
    .HEX5         (HEX5),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // digit codes: 0..15 hex glyph, 16 dash; packed [5] = HEX5
  typedef struct {
    logic [23:0]     value;
    logic            dec;
    logic [5:0][4:0] dig;
  } vec_t;

  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

  function automatic logic [6:0] glyph(input logic [4:0] c);
    case (c)
      5'd0:    return 7'b1000000;
      5'd1:    return 7'b1111001;
      5'd2:    return 7'b0100100;
      5'd3:    return 7'b0110000;
      5'd4:    return 7'b0011001;
      5'd5:    return 7'b0010010;
      5'd6:    return 7'b0000010;
      5'd7:    return 7'b1111000;
      5'd8:    return 7'b0000000;
      5'd9:    return 7'b0010000;
      5'd10:   return 7'b0001000;
      5'd11:   return 7'b0000011;
      5'd12:   return 7'b1000110;
      5'd13:   return 7'b0100001;
      5'd14:   return 7'b0000110;
      5'd15:   return 7'b0001110;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [41:0] model(input logic [5:0][4:0] d);
    logic [41:0] r;
    logic [6:0]  g;
`ifdef LEADING_ZERO_BLANK_EN
    logic        lead;
    lead = 1'b1;
`endif
    r = '0;
    for (int i = 5; i >= 0; i--) begin
      g = glyph(d[i]);
`ifdef LEADING_ZERO_BLANK_EN
      if (d[i] != 5'd0) lead = 1'b0;
      if (lead && (i != 0)) g = 7'h7F;
`endif
      r[7*i +: 7] = g;
    end
    return r;
  endfunction

  function automatic logic [41:0] hex_all();
    return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Counts negedges from the drive point until done is seen; bounded
  task automatic wait_done(output int lat, output int bcyc);
    lat  = 0;
    bcyc = 0;
    do begin
      @(negedge clk);
      result_valid = 1'b0;
      lat++;
      if (busy) bcyc++;
    end while (!done && lat < 100);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat, bcyc;
    @(negedge clk);
    result       = v.value;
    dec_mode     = v.dec;
    result_valid = 1'b1;
    wait_done(lat, bcyc);
    chk({name, "_lat"},  64'(lat),  v.dec ? 64'd26 : 64'd2);
    chk({name, "_busy"}, 64'(bcyc), v.dec ? 64'd24 : 64'd0);
    chk({name, "_hex"},  64'(hex_all()), 64'(model(v.dig)));
    @(negedge clk);
    chk({name, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  vec_t vecs [10];

  initial begin
    int lat, bcyc;

    vecs[0] = '{24'h001B58, 1'b0, {5'd0, 5'd0, 5'd1, 5'd11, 5'd5, 5'd8}};
    vecs[1] = '{24'd7000,    1'b1, {5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd0}};
    vecs[2] = '{24'd1000000, 1'b1, {6{5'd16}}};
    vecs[3] = '{24'd999999,  1'b1, {6{5'd9}}};
    vecs[4] = '{24'hABCDEF,  1'b0, {5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15}};
    vecs[5] = '{24'd0,       1'b1, {6{5'd0}}};
    vecs[6] = '{24'd123456,  1'b1, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6}};
    vecs[7] = '{24'h000100,  1'b0, {5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0}};
    vecs[8] = '{24'hFFFFFF,  1'b1, {6{5'd16}}};
    vecs[9] = '{24'h000000,  1'b0, {6{5'd0}}};

    rst_n        = 1'b0;
    result       = '0;
    result_valid = 1'b0;
    disp_en      = 1'b1;
    dec_mode     = 1'b0;

    // Reset held for three clocks
    repeat (3) @(negedge clk);
    chk("reset_hex",  64'(hex_all()), 64'(ALL_BLANK));
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);

    // Reset together with a valid strobe: reset only
    result       = 24'd5;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    rst_n        = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_hex",  64'(hex_all()), 64'(ALL_BLANK));
    chk("post_reset_done", 64'(done), 64'd0);

    for (int i = 0; i < 10; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Capture attempt during a conversion is dropped
    @(negedge clk);
    result       = 24'd7000;
    dec_mode     = 1'b1;
    result_valid = 1'b1;
    lat  = 0;
    bcyc = 0;
    do begin
      @(negedge clk);
      result_valid = 1'b0;
      lat++;
      if (busy) bcyc++;
      if (lat == 5) begin
        result       = 24'd123;
        result_valid = 1'b1;
      end
    end while (!done && lat < 100);
    chk("ignore_lat",  64'(lat),  64'd26);
    chk("ignore_busy", 64'(bcyc), 64'd24);
    chk("ignore_hex",  64'(hex_all()), 64'(model(vecs[1].dig)));

    // Display enable is combinational
    @(negedge clk);
    disp_en = 1'b0;
    #1;
    chk("disp_off_hex", 64'(hex_all()), 64'(ALL_BLANK));
    @(negedge clk);
    disp_en = 1'b1;
    #1;
    chk("disp_on_hex", 64'(hex_all()), 64'(model(vecs[1].dig)));

    // Mode toggle while showing re-renders the held value in hex
    @(negedge clk);
    dec_mode = 1'b0;
    wait_done(lat, bcyc);
    chk("toggle_lat", 64'(lat), 64'd2);
    chk("toggle_hex", 64'(hex_all()), 64'(model(vecs[0].dig)));

    // Reset in the middle of a conversion
    @(negedge clk);
    result       = 24'd7000;
    dec_mode     = 1'b1;
    result_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      result_valid = 1'b0;
    end
    chk("midconv_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midconv_rst_busy", 64'(busy), 64'd0);
    chk("midconv_rst_hex",  64'(hex_all()), 64'(ALL_BLANK));
    chk("midconv_rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    run_vec("after_rst", vecs[3]);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
